// File: rtl/regfile_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : regfile_pkg
//  Description : Shared constants and the operand-fetch state encoding used
//                by regfile_operand_fetch and rf_wb_stage.
//  Revision    : 1.0 - initial release
// ============================================================================
package regfile_pkg;

    localparam int RF_DATA_W = 32;  // operand / register width
    localparam int RF_ADDR_W = 5;   // register index width

    // Operand-fetch sequencer states
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RD_A = 2'd1,
        ST_RD_B = 2'd2,
        ST_DONE = 2'd3
    } fetch_state_t;

endpackage : regfile_pkg
`default_nettype wire

// File: rtl/rf_wb_stage.sv
`default_nettype none
// ============================================================================
//  Module      : rf_wb_stage
//  Description : Registered register-file write port. Writeback requests are
//                registered once and forwarded unconditionally (no
//                back-pressure). A synchronous reset discards any request
//                presented in the reset cycle.
//  Config      : ZERO_REG_EN - writebacks to index 0 are dropped.
//  Ports       : clk, reset                    - clock, sync active-high reset
//                wb_valid, wb_addr, wb_data    - writeback request
//                rf_w_enable, rf_w_address,
//                rf_data_in                    - to register file write port
//  Revision    : 1.0 - initial release
// ============================================================================
module rf_wb_stage
    import regfile_pkg::*;
#(
    parameter int DATA_W = RF_DATA_W,
    parameter int ADDR_W = RF_ADDR_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wb_valid,
    input  logic [ADDR_W-1:0] wb_addr,
    input  logic [DATA_W-1:0] wb_data,
    output logic              rf_w_enable,
    output logic [ADDR_W-1:0] rf_w_address,
    output logic [DATA_W-1:0] rf_data_in
);

    logic              w_keep;
    logic              r_w_enable;
    logic [ADDR_W-1:0] r_w_address;
    logic [DATA_W-1:0] r_data_in;

`ifdef ZERO_REG_EN
    // Register 0 is hardwired to zero, so writes to it never reach the file.
    assign w_keep = (wb_addr != '0);
`else
    assign w_keep = 1'b1;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            r_w_enable  <= 1'b0;
            r_w_address <= '0;
            r_data_in   <= '0;
        end else begin
            r_w_enable  <= wb_valid && w_keep;
            r_w_address <= wb_addr;
            r_data_in   <= wb_data;
        end
    end

    assign rf_w_enable  = r_w_enable;
    assign rf_w_address = r_w_address;
    assign rf_data_in   = r_data_in;

endmodule : rf_wb_stage
`default_nettype wire

// File: rtl/regfile_operand_fetch.sv
`default_nettype none
// ============================================================================
//  Module      : regfile_operand_fetch
//  Description : Initiator side of the register-file interface. Accepts an
//                operand-fetch request (rs, rt), sequences reads over the
//                file's single read port and returns the operands through a
//                valid/ready handshake. Also owns the file's write port via
//                rf_wb_stage, with a write-to-read bypass.
//  Config      : ZERO_REG_EN - register 0 reads as zero without a file
//                access; writebacks to index 0 are dropped.
//  Ports       : clk, reset                          - clock, sync reset
//                req_valid/ready, req_rs/rt/two_op   - fetch request
//                op_valid/ready, op_a, op_b          - operand response
//                wb_valid, wb_addr, wb_data          - writeback request
//                rf_r_address, rf_r_enable,
//                rf_data_out                         - file read port
//                rf_w_address, rf_w_enable,
//                rf_data_in                          - file write port
//  Revision    : 1.0 - initial release
// ============================================================================
module regfile_operand_fetch
    import regfile_pkg::*;
#(
    parameter int DATA_W = RF_DATA_W,
    parameter int ADDR_W = RF_ADDR_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_rs,
    input  logic [ADDR_W-1:0] req_rt,
    input  logic              req_two_op,
    output logic              op_valid,
    input  logic              op_ready,
    output logic [DATA_W-1:0] op_a,
    output logic [DATA_W-1:0] op_b,
    input  logic              wb_valid,
    input  logic [ADDR_W-1:0] wb_addr,
    input  logic [DATA_W-1:0] wb_data,
    output logic [ADDR_W-1:0] rf_r_address,
    output logic              rf_r_enable,
    input  logic [DATA_W-1:0] rf_data_out,
    output logic [ADDR_W-1:0] rf_w_address,
    output logic              rf_w_enable,
    output logic [DATA_W-1:0] rf_data_in
);

    fetch_state_t      r_state;
    logic [ADDR_W-1:0] r_rs;
    logic [ADDR_W-1:0] r_rt;
    logic              r_two_op;
    logic              r_req_ready;
    logic              r_op_valid;
    logic [DATA_W-1:0] r_op_a;
    logic [DATA_W-1:0] r_op_b;

    logic [ADDR_W-1:0] w_rd_idx;
    logic              w_rd_cycle;
    logic              w_rd_zero;
    logic              w_bypass;
    logic [DATA_W-1:0] w_rd_data;

    rf_wb_stage #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_wb_stage (
        .clk          (clk),
        .reset        (reset),
        .wb_valid     (wb_valid),
        .wb_addr      (wb_addr),
        .wb_data      (wb_data),
        .rf_w_enable  (rf_w_enable),
        .rf_w_address (rf_w_address),
        .rf_data_in   (rf_data_in)
    );

    // Read index is only presented during the two read states; the port is
    // parked at index 0 otherwise.
    always_comb begin
        w_rd_idx   = '0;
        w_rd_cycle = 1'b0;
        case (r_state)
            ST_RD_A: begin
                w_rd_idx   = r_rs;
                w_rd_cycle = 1'b1;
            end
            ST_RD_B: begin
                w_rd_idx   = r_rt;
                w_rd_cycle = 1'b1;
            end
            default: begin
                w_rd_idx   = '0;
                w_rd_cycle = 1'b0;
            end
        endcase
    end

`ifdef ZERO_REG_EN
    assign w_rd_zero = (w_rd_idx == '0);
`else
    assign w_rd_zero = 1'b0;
`endif

    // The write sitting on the file's write port lands at the same edge that
    // closes this read, so the file's combinational read data is still stale.
    assign w_bypass  = rf_w_enable && (rf_w_address == w_rd_idx);
    assign w_rd_data = w_rd_zero ? '0 : (w_bypass ? rf_data_in : rf_data_out);

    assign rf_r_address = w_rd_idx;
    assign rf_r_enable  = w_rd_cycle && !w_rd_zero;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_rs        <= '0;
            r_rt        <= '0;
            r_two_op    <= 1'b0;
            r_req_ready <= 1'b1;
            r_op_valid  <= 1'b0;
            r_op_a      <= '0;
            r_op_b      <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (req_valid) begin
                        r_rs        <= req_rs;
                        r_rt        <= req_rt;
                        r_two_op    <= req_two_op;
                        r_req_ready <= 1'b0;
                        r_state     <= ST_RD_A;
                    end
                end
                ST_RD_A: begin
                    r_op_a <= w_rd_data;
                    if (r_two_op) begin
                        r_state <= ST_RD_B;
                    end else begin
                        r_op_b  <= '0;
                        r_state <= ST_DONE;
                    end
                end
                ST_RD_B: begin
                    r_op_b  <= w_rd_data;
                    r_state <= ST_DONE;
                end
                ST_DONE: begin
                    // op_valid is registered off DONE, so it rises one edge
                    // after the last capture; op_ready is ignored until then.
                    if (!r_op_valid) begin
                        r_op_valid <= 1'b1;
                    end else if (op_ready) begin
                        r_op_valid  <= 1'b0;
                        r_req_ready <= 1'b1;
                        r_state     <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign req_ready = r_req_ready;
    assign op_valid  = r_op_valid;
    assign op_a      = r_op_a;
    assign op_b      = r_op_b;

endmodule : regfile_operand_fetch
`default_nettype wire
